booth_radix4_multiplier: RTL and testbench



---
 rtl/booth_radix4_multiplier.sv | 131 +++++++++++++
 tb/tb_booth_radix4_multiplier.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_radix4_multiplier.sv
// Sequential signed radix-4 Booth multiplier: one 3-bit Booth group per clock,
// accumulated into a WIDTH+2 bit accumulator that shifts right with the multiplier.

module booth_r4_encoder (
    input  logic [2:0] i_bits,
    output logic [2:0] o_sel
);
    // Select codes: 1 = -2A, 2 = -A, 3 = 0, 4 = +A, 5 = +2A
    always_comb begin
        o_sel = 3'd3;
        case (i_bits)
            3'b000, 3'b111: o_sel = 3'd3;
            3'b001, 3'b010: o_sel = 3'd4;
            3'b011:         o_sel = 3'd5;
            3'b100:         o_sel = 3'd1;
            3'b101, 3'b110: o_sel = 3'd2;
            default:        o_sel = 3'd3;
        endcase
    end
endmodule

// state | meaning
// IDLE  | waiting for an accepted start
// EXEC  | one Booth group retired per clock, busy high
// DONE  | single cycle with op_done high; a start here begins the next product
module booth_radix4_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   op_start,
    input  logic                   op_clear,
    input  logic [WIDTH-1:0]       multiplicand,
    input  logic [WIDTH-1:0]       multiplier,
    output logic                   busy,
    output logic                   op_done,
    output logic [2*WIDTH-1:0]     result
);
    localparam int AW    = WIDTH + 2;
    localparam int CNT_W = $clog2(WIDTH / 2) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH / 2 - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]              r_state;
    logic signed [AW-1:0]    r_acc;
    logic [WIDTH:0]          r_mq;
    logic signed [AW-1:0]    r_a;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_done;
    logic [2*WIDTH-1:0]      r_result;

    logic [2:0]              w_sel;
    logic signed [AW-1:0]    w_pp;
    logic signed [AW-1:0]    w_sum;
    logic signed [AW+WIDTH:0] w_shift;
    logic                    w_last;

    booth_r4_encoder u_enc (
        .i_bits (r_mq[2:0]),
        .o_sel  (w_sel)
    );

    // 2A is formed inside the AW-bit domain; the two extra bits keep -2^(WIDTH-1) exact.
    always_comb begin
        w_pp = '0;
        case (w_sel)
            3'd1:    w_pp = -(r_a <<< 1);
            3'd2:    w_pp = -r_a;
            3'd4:    w_pp = r_a;
            3'd5:    w_pp = r_a <<< 1;
            default: w_pp = '0;
        endcase
    end

    assign w_sum   = r_acc + w_pp;
    assign w_shift = $signed({w_sum, r_mq}) >>> 2;
    assign w_last  = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mq     <= '0;
            r_a      <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (op_clear) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mq     <= '0;
            r_a      <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (op_start) begin
                        r_a     <= {{2{multiplicand[WIDTH-1]}}, multiplicand};
                        r_acc   <= '0;
                        r_mq    <= {multiplier, 1'b0};
                        r_cnt   <= '0;
                        r_state <= S_EXEC;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    r_acc <= w_shift[AW+WIDTH:WIDTH+1];
                    r_mq  <= w_shift[WIDTH:0];
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_result <= w_shift[2*WIDTH:1];
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = (r_state == S_EXEC);
    assign op_done = r_done;
    assign result  = r_result;
endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Bench for booth_radix4_multiplier: directed vectors and corner sequences at WIDTH=8,
// randomized products at WIDTH=8 and WIDTH=32 against a plain-arithmetic reference.

module tb_booth_radix4_multiplier;
    logic        clk;
    logic        reset_n;

    logic        s8_start, s8_clear;
    logic [7:0]  s8_a, s8_b;
    logic        o8_busy, o8_done;
    logic [15:0] o8_result;

    logic        s32_start, s32_clear;
    logic [31:0] s32_a, s32_b;
    logic        o32_busy, o32_done;
    logic [63:0] o32_result;

    int n_checks = 0;
    int n_fail   = 0;

    booth_radix4_multiplier #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .reset_n      (reset_n),
        .op_start     (s8_start),
        .op_clear     (s8_clear),
        .multiplicand (s8_a),
        .multiplier   (s8_b),
        .busy         (o8_busy),
        .op_done      (o8_done),
        .result       (o8_result)
    );

    booth_radix4_multiplier #(.WIDTH(32)) dut32 (
        .clk          (clk),
        .reset_n      (reset_n),
        .op_start     (s32_start),
        .op_clear     (s32_clear),
        .multiplicand (s32_a),
        .multiplier   (s32_b),
        .busy         (o32_busy),
        .op_done      (o32_done),
        .result       (o32_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
        int x, y;
        x = int'($signed(a));
        y = int'($signed(b));
        return 16'(x * y);
    endfunction

    function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b);
        longint x, y;
        x = longint'($signed(a));
        y = longint'($signed(b));
        return 64'(x * y);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one product, scrambles the operand inputs after the start edge,
    // and waits (bounded) for op_done.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                        input string nm);
        int n;
        s8_a = a; s8_b = b; s8_start = 1'b1;
        tick();
        s8_start = 1'b0;
        s8_a = 8'($urandom); s8_b = 8'($urandom);
        check({nm, "_busy_start"}, 64'(o8_busy), 64'd1);
        n = 0;
        while (!o8_done && n < 40) begin
            tick();
            n++;
        end
        check({nm, "_latency"}, 64'(n), 64'd4);
        check({nm, "_result"}, 64'(o8_result), 64'(exp));
        check({nm, "_busy_done"}, 64'(o8_busy), 64'd0);
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input string nm);
        int n;
        s32_a = a; s32_b = b; s32_start = 1'b1;
        tick();
        s32_start = 1'b0;
        s32_a = $urandom; s32_b = $urandom;
        n = 0;
        while (!o32_done && n < 60) begin
            tick();
            n++;
        end
        check({nm, "_latency"}, 64'(n), 64'd16);
        check({nm, "_result"}, o32_result, ref32(a, b));
    endtask

    initial begin
        vec_t tbl[10];
        int   pulses;
        int   n;

        tbl[0] = '{8'd7,    8'd3,    16'h0015};
        tbl[1] = '{8'd7,    8'hFD,   16'hFFEB};
        tbl[2] = '{8'h80,   8'h80,   16'h4000};
        tbl[3] = '{8'h80,   8'd127,  16'hC080};
        tbl[4] = '{8'd0,    8'hFF,   16'h0000};
        tbl[5] = '{8'd3,    8'd4,    16'h000C};
        tbl[6] = '{8'd5,    8'd5,    16'h0019};
        tbl[7] = '{8'hFA,   8'd9,    16'hFFCA};
        tbl[8] = '{8'd127,  8'd127,  16'h3F01};
        tbl[9] = '{8'hFF,   8'hFF,   16'h0001};

        reset_n = 1'b0;
        s8_start = 0; s8_clear = 0; s8_a = 0; s8_b = 0;
        s32_start = 0; s32_clear = 0; s32_a = 0; s32_b = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        check("reset_busy",   64'(o8_busy),   64'd0);
        check("reset_done",   64'(o8_done),   64'd0);
        check("reset_result", 64'(o8_result), 64'd0);

        for (int i = 0; i < 10; i++) begin
            run8(tbl[i].a, tbl[i].b, tbl[i].p, $sformatf("vec%0d", i));
            tick();
            check($sformatf("vec%0d_pulse", i), 64'(o8_done), 64'd0);
            check($sformatf("vec%0d_hold", i), 64'(o8_result), 64'(tbl[i].p));
        end

        // Back-to-back: op_start stays high through EXEC (ignored) and DONE (accepted).
        s8_a = 8'd5; s8_b = 8'd5; s8_start = 1'b1;
        tick();
        s8_a = 8'hFA; s8_b = 8'd9;
        n = 0;
        while (!o8_done && n < 40) begin tick(); n++; end
        check("b2b_first_latency", 64'(n), 64'd4);
        check("b2b_first_result", 64'(o8_result), 64'h0019);
        tick();
        s8_start = 1'b0;
        check("b2b_restart_busy", 64'(o8_busy), 64'd1);
        n = 1;
        while (!o8_done && n < 40) begin tick(); n++; end
        check("b2b_gap", 64'(n), 64'd5);
        check("b2b_second_result", 64'(o8_result), 64'hFFCA);
        tick();

        // Abort on the second EXEC edge.
        s8_a = 8'd7; s8_b = 8'd3; s8_start = 1'b1;
        tick();
        s8_start = 1'b0;
        tick();
        s8_clear = 1'b1;
        tick();
        s8_clear = 1'b0;
        check("abort_busy",   64'(o8_busy),   64'd0);
        check("abort_done",   64'(o8_done),   64'd0);
        check("abort_result", 64'(o8_result), 64'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (o8_done) pulses++; end
        check("abort_no_done", 64'(pulses), 64'd0);
        run8(8'd3, 8'd4, 16'h000C, "after_abort");
        tick();

        // Clear and start together: start must be dropped.
        s8_a = 8'd9; s8_b = 8'd9; s8_start = 1'b1; s8_clear = 1'b1;
        tick();
        s8_start = 1'b0; s8_clear = 1'b0;
        check("clear_wins_busy", 64'(o8_busy), 64'd0);
        check("clear_wins_result", 64'(o8_result), 64'd0);
        run8(8'd3, 8'd4, 16'h000C, "before_reset");
        tick();

        // Asynchronous reset between edges in the middle of EXEC.
        s8_a = 8'd7; s8_b = 8'd3; s8_start = 1'b1;
        tick();
        s8_start = 1'b0;
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("areset_busy",   64'(o8_busy),   64'd0);
        check("areset_done",   64'(o8_done),   64'd0);
        check("areset_result", 64'(o8_result), 64'd0);
        #10 reset_n = 1'b1;
        pulses = 0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (o8_done) pulses++;
            if (o8_busy) n++;
        end
        check("areset_no_done", 64'(pulses), 64'd0);
        check("areset_no_busy", 64'(n), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            run8(ra, rb, ref8(ra, rb), "rand8");
        end

        run32(32'h8000_0000, 32'h8000_0000, "w32_minsq");
        run32(32'h8000_0000, 32'h7FFF_FFFF, "w32_minmax");
        run32(32'hFFFF_FFFF, 32'h7FFF_FFFF, "w32_neg1max");
        for (int i = 0; i < 1000; i++) begin
            run32($urandom, $urandom, "rand32");
        end
        tick();
        check("w32_idle_busy", 64'(o32_busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
